// File: rtl/forward_control.sv
// Operand-forwarding and load-use interlock for a 5-stage pipeline: tracks the
// instructions in execute and memory and picks the bypass source for each operand.
module forward_control #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_src,
  input  logic [REG_BITS-1:0] id_dst,
  input  logic                id_use_src,
  input  logic                id_reg_op2,
  input  logic                id_writes,
  input  logic [REG_BITS-1:0] id_wreg,
  input  logic                id_is_load,
  input  logic                flush,
  output logic [1:0]          selectSrc,
  output logic [1:0]          selectDst,
  output logic                stall,
  output logic [CNT_BITS-1:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  // Tag records for the instructions currently in execute and memory.
  logic                exValidReg, exWritesReg, exIsLoadReg;
  logic [REG_BITS-1:0] exWregReg;
  logic                memValidReg, memWritesReg;
  logic [REG_BITS-1:0] memWregReg;

  logic [1:0]          selectSrcReg, selectDstReg;
  logic [CNT_BITS-1:0] stallCountReg;

  // Operand 0 is the first (src) operand, operand 1 the second (dst) operand.
  logic [REG_BITS-1:0] opIdx [2];
  logic [1:0]          opUsed;
  logic [1:0]          opMatchEx;
  logic [1:0]          opMatchMem;
  logic [1:0]          opSel [2];

  assign opIdx[0] = id_src;
  assign opIdx[1] = id_dst;
  assign opUsed   = {id_reg_op2, id_use_src};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gOperand
      assign opMatchEx[gi]  = opUsed[gi] & exValidReg & exWritesReg & (exWregReg == opIdx[gi]);
      assign opMatchMem[gi] = opUsed[gi] & memValidReg & memWritesReg & (memWregReg == opIdx[gi]);
      // Nearer producer wins; a bubble or unread operand always takes the register file.
      assign opSel[gi] = !id_valid      ? SEL_RF  :
                         opMatchEx[gi]  ? SEL_EX  :
                         opMatchMem[gi] ? SEL_MEM : SEL_RF;
    end
  endgenerate

  // A load in execute cannot forward yet; hold decode one cycle so it moves to memory.
  assign stall = ~reset & id_valid & ~flush & exIsLoadReg & (|opMatchEx);

  always_ff @(posedge clk) begin
    if (reset) begin
      exValidReg    <= 1'b0;
      exWritesReg   <= 1'b0;
      exIsLoadReg   <= 1'b0;
      exWregReg     <= '0;
      memValidReg   <= 1'b0;
      memWritesReg  <= 1'b0;
      memWregReg    <= '0;
      selectSrcReg  <= SEL_RF;
      selectDstReg  <= SEL_RF;
      stallCountReg <= '0;
    end else if (flush) begin
      exValidReg   <= 1'b0;
      memValidReg  <= 1'b0;
      selectSrcReg <= SEL_RF;
      selectDstReg <= SEL_RF;
    end else begin
      memValidReg  <= exValidReg;
      memWritesReg <= exWritesReg;
      memWregReg   <= exWregReg;
      if (stall) begin
        exValidReg   <= 1'b0;
        selectSrcReg <= SEL_RF;
        selectDstReg <= SEL_RF;
        if (~&stallCountReg) stallCountReg <= stallCountReg + CNT_ONE;
      end else begin
        exValidReg   <= id_valid;
        exWritesReg  <= id_writes;
        exIsLoadReg  <= id_is_load;
        exWregReg    <= id_wreg;
        selectSrcReg <= opSel[0];
        selectDstReg <= opSel[1];
      end
    end
  end

  assign selectSrc   = selectSrcReg;
  assign selectDst   = selectDstReg;
  assign stall_count = stallCountReg;

endmodule

// File: doc/forward_control.md
FORWARD_CONTROL -- requirements
Module: forward_control

Interface
REQ-001 Parameter REG_BITS, default 3, register-index width (8 architectural registers).
REQ-002 Parameter CNT_BITS, default 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_src  in  REG_BITS  first-operand register index.
REQ-007 id_dst  in  REG_BITS  second-operand register index.
REQ-008 id_use_src  in  1  first operand read from register file.
REQ-009 id_reg_op2  in  1  second operand is register (1) or immediate (0); same sense as the execute-stage ImmOrReg.
REQ-010 id_writes  in  1  instruction writes a register.
REQ-011 id_wreg  in  REG_BITS  written register index.
REQ-012 id_is_load  in  1  write data comes from memory, not the ALU.
REQ-013 flush  in  1  squash decode instruction and EX-stage record (taken branch/interrupt).
REQ-014 selectSrc  out  2  registered first-operand mux select for the execute stage: 00 register file, 01 from EX/MEM, 10 from MEM/WB.
REQ-015 selectDst  out  2  registered second-operand select, same encoding.
REQ-016 stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-017 stall_count  out  CNT_BITS  number of load-use stall cycles since reset.

Function
REQ-018 Block SHALL keep two tag records, EX and MEM, each {valid, writes, wreg, is_load}, mirroring the instructions in execute and memory stages.
REQ-019 Hazard match vs record R SHALL mean R.valid & R.writes & R.wreg == operand index & operand actually read from register.
REQ-020 First operand is read iff id_use_src; second operand is read iff id_reg_op2.
REQ-021 stall SHALL be 1 iff id_valid & ~flush & EX.is_load & hazard match vs EX on either read operand.
REQ-022 On a non-stall, non-flush edge: EX <= decode fields (valid=id_valid), MEM <= EX; selectSrc/selectDst SHALL be loaded for the instruction entering execute.
REQ-023 Select rule per read operand: match vs EX -> 01; else match vs MEM -> 10; else 00; EX match has priority over MEM.
REQ-024 Unread operand SHALL get select 00; in particular id_reg_op2=0 forces selectDst=00 so the immediate is never overridden.
REQ-025 On a stall edge: EX <= bubble (valid=0), MEM <= EX, both selects <= 00, stall_count increments.
REQ-026 After a one-cycle load-use stall the load sits in MEM, so the dependent instruction SHALL receive select 10 on the next edge; no second stall.
REQ-027 On a flush edge: EX <= bubble, MEM <= bubble, selects <= 00; flush overrides stall (stall forced 0, counter not incremented).
REQ-028 id_valid=0 SHALL enter EX as a bubble with selects 00.
REQ-029 Select value 11 SHALL never be produced.
REQ-030 stall_count SHALL saturate at all-ones, no wrap.
REQ-031 Selects are valid during the cycle the instruction occupies execute, i.e. one edge after it is presented on id_*.

Reset
REQ-032 On reset edge: EX and MEM records invalid, selectSrc=selectDst=00, stall_count=0; reset overrides flush and stall.
REQ-033 While reset is high, stall SHALL be 0.
REQ-034 Reset asserted mid-stall SHALL drop the pending stall; first instruction after reset gets selects 00.

Verification
REQ-035 ADD R1 (writes R1) then ADD src=R1,dst=R2 reg -> second instruction gets selectSrc=01, selectDst=00, stall never asserted.
REQ-036 Writer R3, unrelated instr, reader src=R3 -> selectSrc=10; writers R3 at both distances -> selectSrc=01 (EX priority).
REQ-037 LDD R4 then ADD src=R4 -> stall=1 one cycle, bubble selects 00, stall_count=1, next edge selectSrc=10.
REQ-038 Writer R5 then reader id_dst=R5 with id_reg_op2=0 -> selectDst=00; with id_reg_op2=1 -> selectDst=01.
REQ-039 Load-use hazard with flush=1 same cycle -> stall=0, selects 00, stall_count unchanged, EX and MEM records invalid.
REQ-040 Force stall_count to all-ones via repeated load-use pairs (CNT_BITS=4 build: 16 stalls) -> count holds 15; reset -> count 0, selects 00.
